// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared constants for the multi-cycle RV64 control FSM:
// opcodes, state encodings, ALU op codes and trap causes.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_BRANCH = 3'd6,
    ST_TRAP   = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    TC_NONE    = 2'd0,
    TC_ILLEGAL = 2'd1,
    TC_IMEM_TO = 2'd2,
    TC_DMEM_TO = 2'd3
  } cause_e;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_IMM,
    CLS_LD,
    CLS_SD,
    CLS_BR,
    CLS_ILL
  } cls_e;

  function automatic cls_e decode_cls(
    input logic [6:0] op,
    input logic [2:0] f3
  );
    cls_e c;
    c = CLS_ILL;
    unique case (1'b1)
      op == OP_R:   c = CLS_R;
      op == OP_IMM: c = CLS_IMM;
      op == OP_LD:  c = CLS_LD;
      op == OP_SD:  c = CLS_SD;
      op == OP_BR && f3 == F3_BEQ:
        c = CLS_BR;
      default:      c = CLS_ILL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Handshake/control bundle between the control FSM (master)
// and the multi-cycle datapath (slave).
interface multicycle_ctrl_fsm_if #(
  parameter int CNT_W = 64
);
  logic             run;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             zero;
  logic             imem_ready;
  logic             dmem_ready;
  logic             ir_write;
  logic             pc_write;
  logic             pc_src;
  logic             imem_req;
  logic             reg_write;
  logic             alu_src;
  logic [1:0]       alu_op;
  logic             mem_read;
  logic             mem_write;
  logic             mem_to_reg;
  logic [2:0]       state;
  logic             trap;
  logic [1:0]       trap_cause;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;

  modport master (
    input  run, opcode, funct3, zero,
    input  imem_ready, dmem_ready,
    output ir_write, pc_write, pc_src,
    output imem_req, reg_write, alu_src,
    output alu_op, mem_read, mem_write,
    output mem_to_reg, state, trap,
    output trap_cause, cycle_cnt,
    output instret_cnt
  );

  modport slave (
    output run, opcode, funct3, zero,
    output imem_ready, dmem_ready,
    input  ir_write, pc_write, pc_src,
    input  imem_req, reg_write, alu_src,
    input  alu_op, mem_read, mem_write,
    input  mem_to_reg, state, trap,
    input  trap_cause, cycle_cnt,
    input  instret_cnt
  );
endinterface

// File: rtl/multicycle_ctrl_fsm_timer.sv
// Wait timer shared by FETCH and MEM stalls; expire fires on
// the TIMEOUT-th consecutive not-ready cycle (TIMEOUT=0: never).
module ctrl_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  generate
    if (TIMEOUT == 0) begin : g_off
      assign expire = 1'b0;
    end else begin : g_on
      localparam int W =
        (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

      logic [W-1:0] cnt_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_q <= '0;
        end else if (clr) begin
          cnt_q <= '0;
        end else if (inc) begin
          cnt_q <= cnt_q + W'(1);
        end
      end

      assign expire =
        inc && (cnt_q == W'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV64 control FSM. Define PERF_CNT_EN to build
// the cycle/instret performance counters (else tied to 0).
module multicycle_ctrl_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int CNT_W   = 64,
  parameter int TIMEOUT = 16
) (
  input logic                 clk,
  input logic                 reset,
  multicycle_ctrl_fsm_if.master bus
);

  state_e state_q, state_d;
  cause_e cause_q, cause_d;
  cls_e   cls_q, cls_d;
  state_e retire_st;

  logic wait_st, ready, t_clr, t_inc, t_exp;

  assign wait_st = (state_q == ST_FETCH) ||
                   (state_q == ST_MEM);
  assign ready   = (state_q == ST_FETCH) ?
                   bus.imem_ready : bus.dmem_ready;
  assign t_inc   = wait_st && !ready;
  assign t_clr   = (state_d == ST_FETCH ||
                    state_d == ST_MEM) &&
                   (state_d != state_q);

  ctrl_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (t_clr),
    .inc    (t_inc),
    .expire (t_exp)
  );

  assign retire_st = bus.run ? ST_FETCH : ST_IDLE;

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    cls_d   = cls_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (bus.imem_ready) begin
          state_d = ST_DECODE;
        end else if (t_exp) begin
          state_d = ST_TRAP;
          cause_d = TC_IMEM_TO;
        end
      end
      ST_DECODE: begin
        cls_d = decode_cls(bus.opcode, bus.funct3);
        if (cls_d == CLS_BR) begin
          state_d = ST_BRANCH;
        end else if (cls_d == CLS_ILL) begin
          state_d = ST_TRAP;
          cause_d = TC_ILLEGAL;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cls_q == CLS_LD || cls_q == CLS_SD)
          state_d = ST_MEM;
        else
          state_d = ST_WB;
      end
      ST_MEM: begin
        if (bus.dmem_ready) begin
          state_d = (cls_q == CLS_LD) ?
                    ST_WB : retire_st;
        end else if (t_exp) begin
          state_d = ST_TRAP;
          cause_d = TC_DMEM_TO;
        end
      end
      ST_WB:     state_d = retire_st;
      ST_BRANCH: state_d = retire_st;
      default:   state_d = ST_TRAP;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cause_q <= TC_NONE;
      cls_q   <= CLS_ILL;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      cls_q   <= cls_d;
    end
  end

  logic       ir_w, pc_w, pc_s, ireq;
  logic       reg_w, a_src, mem_rd, mem_wr, m2r;
  logic [1:0] a_op;

  // Decoded from the registered state; only FETCH and BRANCH
  // qualify their PC/IR strobes with the same-cycle inputs.
  always_comb begin
    ir_w   = 1'b0;
    pc_w   = 1'b0;
    pc_s   = 1'b0;
    ireq   = 1'b0;
    reg_w  = 1'b0;
    a_src  = 1'b0;
    a_op   = ALU_OP_ADD;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    m2r    = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        ireq = 1'b1;
        ir_w = bus.imem_ready;
        pc_w = bus.imem_ready;
      end
      ST_EXEC: begin
        a_src = (cls_q != CLS_R);
        a_op  = (cls_q == CLS_LD ||
                 cls_q == CLS_SD) ?
                ALU_OP_ADD : ALU_OP_FUNCT;
      end
      ST_MEM: begin
        mem_rd = (cls_q == CLS_LD);
        mem_wr = (cls_q == CLS_SD);
      end
      ST_WB: begin
        reg_w = 1'b1;
        m2r   = (cls_q == CLS_LD);
      end
      ST_BRANCH: begin
        a_op = ALU_OP_SUB;
        pc_w = bus.zero;
        pc_s = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.ir_write   = ir_w;
  assign bus.pc_write   = pc_w;
  assign bus.pc_src     = pc_s;
  assign bus.imem_req   = ireq;
  assign bus.reg_write  = reg_w;
  assign bus.alu_src    = a_src;
  assign bus.alu_op     = a_op;
  assign bus.mem_read   = mem_rd;
  assign bus.mem_write  = mem_wr;
  assign bus.mem_to_reg = m2r;
  assign bus.state      = state_q;
  assign bus.trap       = (state_q == ST_TRAP);
  assign bus.trap_cause = cause_q;

`ifdef PERF_CNT_EN
  logic             retire;
  logic [CNT_W-1:0] cyc_q, ret_q;

  assign retire =
    (state_q == ST_WB) ||
    (state_q == ST_BRANCH) ||
    (state_q == ST_MEM && cls_q == CLS_SD &&
     bus.dmem_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      if (state_q != ST_IDLE && state_q != ST_TRAP)
        cyc_q <= cyc_q + CNT_W'(1);
      if (retire)
        ret_q <= ret_q + CNT_W'(1);
    end
  end

  assign bus.cycle_cnt   = cyc_q;
  assign bus.instret_cnt = ret_q;
`else
  assign bus.cycle_cnt   = {CNT_W{1'b0}};
  assign bus.instret_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed, table-driven bench for multicycle_ctrl_fsm plus
// hand sequences for stalls, timeouts, traps and async reset.
module tb_multicycle_ctrl_fsm;

  localparam logic [6:0] O_R  = 7'h33;
  localparam logic [6:0] O_I  = 7'h13;
  localparam logic [6:0] O_LD = 7'h03;
  localparam logic [6:0] O_SD = 7'h23;
  localparam logic [6:0] O_BR = 7'h63;
  localparam logic [6:0] O_BD = 7'h7F;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_F    = 3'd1;
  localparam logic [2:0] S_D    = 3'd2;
  localparam logic [2:0] S_E    = 3'd3;
  localparam logic [2:0] S_M    = 3'd4;
  localparam logic [2:0] S_WB   = 3'd5;
  localparam logic [2:0] S_BR   = 3'd6;
  localparam logic [2:0] S_TRAP = 3'd7;

  // {ir_write,pc_write,pc_src,imem_req,reg_write,alu_src,
  //  alu_op[1:0],mem_read,mem_write,mem_to_reg,trap}
  localparam logic [11:0] C_0    = 12'h000;
  localparam logic [11:0] C_F    = 12'hD00;
  localparam logic [11:0] C_EXR  = 12'h020;
  localparam logic [11:0] C_EXI  = 12'h060;
  localparam logic [11:0] C_EXM  = 12'h040;
  localparam logic [11:0] C_MLD  = 12'h008;
  localparam logic [11:0] C_MSD  = 12'h004;
  localparam logic [11:0] C_WB   = 12'h080;
  localparam logic [11:0] C_WBL  = 12'h082;
  localparam logic [11:0] C_BRT  = 12'h610;
  localparam logic [11:0] C_BRN  = 12'h210;
  localparam logic [11:0] C_TRAP = 12'h001;

`ifdef PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct {
    logic        run;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        z;
    logic [2:0]  st;
    logic [11:0] ctl;
    logic [1:0]  cause;
    bit          cchk;
    logic [63:0] cyc;
    logic [63:0] ret;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_ctrl_fsm_if #(.CNT_W(64)) bus();

  multicycle_ctrl_fsm #(
    .CNT_W   (64),
    .TIMEOUT (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [11:0] ctl_now();
    return {bus.ir_write, bus.pc_write, bus.pc_src,
            bus.imem_req, bus.reg_write, bus.alu_src,
            bus.alu_op, bus.mem_read, bus.mem_write,
            bus.mem_to_reg, bus.trap};
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r,
                       input logic [6:0] op,
                       input logic [2:0] f3,
                       input logic z,
                       input logic ir,
                       input logic dr);
    bus.run        = r;
    bus.opcode     = op;
    bus.funct3     = f3;
    bus.zero       = z;
    bus.imem_ready = ir;
    bus.dmem_ready = dr;
  endtask

  task automatic add(input logic r,
                     input logic [6:0] op,
                     input logic [2:0] f3,
                     input logic z,
                     input logic [2:0] st,
                     input logic [11:0] ctl,
                     input logic [1:0] cause,
                     input bit cchk,
                     input logic [63:0] cyc,
                     input logic [63:0] ret);
    vec_t v;
    v.run = r; v.op = op; v.f3 = f3; v.z = z;
    v.st = st; v.ctl = ctl; v.cause = cause;
    v.cchk = cchk; v.cyc = cyc; v.ret = ret;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    drive(0, 7'h0, 3'h0, 0, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [63:0] pc(input int n);
    return PERF ? 64'(n) : 64'd0;
  endfunction

  initial begin
    int n;
    int nrd;

    // main table: zero-wait memory throughout
    add(1, O_LD, 3, 0, S_IDLE, C_0, 0, 0, 0, 0);
    add(1, O_LD, 3, 0, S_F,  C_F,   0, 0, 0, 0);
    add(1, O_LD, 3, 0, S_D,  C_0,   0, 0, 0, 0);
    add(1, O_LD, 3, 0, S_E,  C_EXM, 0, 0, 0, 0);
    add(1, O_LD, 3, 0, S_M,  C_MLD, 0, 0, 0, 0);
    add(1, O_LD, 3, 0, S_WB, C_WBL, 0, 0, 0, 0);
    add(1, O_R,  0, 0, S_F,  C_F,   0, 0, 0, 0);
    add(1, O_R,  0, 0, S_D,  C_0,   0, 0, 0, 0);
    add(1, O_R,  0, 0, S_E,  C_EXR, 0, 0, 0, 0);
    add(1, O_R,  0, 0, S_WB, C_WB,  0, 0, 0, 0);
    add(1, O_SD, 3, 0, S_F,  C_F,   0, 0, 0, 0);
    add(1, O_SD, 3, 0, S_D,  C_0,   0, 0, 0, 0);
    add(1, O_SD, 3, 0, S_E,  C_EXM, 0, 0, 0, 0);
    add(1, O_SD, 3, 0, S_M,  C_MSD, 0, 0, 0, 0);
    add(1, O_BR, 0, 1, S_F,  C_F,   0, 0, 0, 0);
    add(1, O_BR, 0, 1, S_D,  C_0,   0, 0, 0, 0);
    add(1, O_BR, 0, 1, S_BR, C_BRT, 0, 0, 0, 0);
    add(1, O_BR, 0, 0, S_F,  C_F,   0, 1, pc(16), pc(4));
    add(1, O_BR, 0, 0, S_D,  C_0,   0, 0, 0, 0);
    add(1, O_BR, 0, 0, S_BR, C_BRN, 0, 0, 0, 0);
    add(1, O_I,  0, 0, S_F,  C_F,   0, 1, pc(19), pc(5));
    add(1, O_I,  0, 0, S_D,  C_0,   0, 0, 0, 0);
    add(1, O_I,  0, 0, S_E,  C_EXI, 0, 0, 0, 0);
    add(1, O_I,  0, 0, S_WB, C_WB,  0, 0, 0, 0);
    add(1, O_R,  0, 0, S_F,  C_F,   0, 1, pc(23), pc(6));
    add(1, O_R,  0, 0, S_D,  C_0,   0, 0, 0, 0);
    add(0, O_R,  0, 0, S_E,  C_EXR, 0, 0, 0, 0);
    add(0, O_R,  0, 0, S_WB, C_WB,  0, 0, 0, 0);
    add(0, O_R,  0, 0, S_IDLE, C_0, 0, 0, 0, 0);
    add(0, O_R,  0, 0, S_IDLE, C_0, 0, 1, pc(27), pc(7));
    add(1, O_BD, 0, 0, S_IDLE, C_0, 0, 0, 0, 0);
    add(1, O_BD, 0, 0, S_F,  C_F,   0, 0, 0, 0);
    add(1, O_BD, 0, 0, S_D,  C_0,   0, 0, 0, 0);
    add(1, O_BD, 0, 0, S_TRAP, C_TRAP, 1, 0, 0, 0);

    drive(0, 7'h0, 3'h0, 0, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("rst.state", bus.state, S_IDLE);
    chk("rst.ctl", ctl_now(), C_0);
    chk("rst.cause", bus.trap_cause, 0);
    chk("rst.cyc", bus.cycle_cnt, 0);
    chk("rst.ret", bus.instret_cnt, 0);
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].run, tbl[i].op, tbl[i].f3,
            tbl[i].z, 1'b1, 1'b1);
      #1;
      chk($sformatf("v%0d.state", i),
          bus.state, tbl[i].st);
      chk($sformatf("v%0d.ctl", i),
          ctl_now(), tbl[i].ctl);
      chk($sformatf("v%0d.cause", i),
          bus.trap_cause, tbl[i].cause);
      if (tbl[i].cchk) begin
        chk($sformatf("v%0d.cyc", i),
            bus.cycle_cnt, tbl[i].cyc);
        chk($sformatf("v%0d.ret", i),
            bus.instret_cnt, tbl[i].ret);
      end
      @(negedge clk);
    end

    // trap is sticky with all enables low
    for (int k = 0; k < 20; k++) begin
      drive(1, O_R, 0, 1'($urandom),
            1'($urandom), 1'($urandom));
      #1;
      chk($sformatf("trap%0d.state", k),
          bus.state, S_TRAP);
      chk($sformatf("trap%0d.ctl", k),
          ctl_now(), C_TRAP);
      @(negedge clk);
    end

    // LD with dmem_ready delayed 3 cycles
    do_reset();
    drive(1, O_LD, 3, 0, 1, 0);
    repeat (4) @(negedge clk);
    nrd = 0;
    for (int k = 0; k < 4; k++) begin
      bus.dmem_ready = (k == 3);
      #1;
      chk($sformatf("ldw%0d.state", k),
          bus.state, S_M);
      if (bus.mem_read) nrd++;
      @(negedge clk);
    end
    chk("ldw.nrd", nrd, 4);
    #1;
    chk("ldw.wb.state", bus.state, S_WB);
    chk("ldw.wb.ctl", ctl_now(), C_WBL);
    @(negedge clk);

    // async reset while stalled in MEM
    do_reset();
    drive(1, O_LD, 3, 0, 1, 0);
    repeat (5) @(negedge clk);
    #1;
    chk("arst.pre.rd", bus.mem_read, 1);
    #1;
    reset = 1'b1;
    #1;
    chk("arst.state", bus.state, S_IDLE);
    chk("arst.rd", bus.mem_read, 0);
    chk("arst.ctl", ctl_now(), C_0);
    @(negedge clk);
    reset = 1'b0;

    // dmem timeout
    do_reset();
    drive(1, O_LD, 3, 0, 1, 0);
    repeat (4) @(negedge clk);
    n = 0;
    while (bus.state == S_M && n < 40) begin
      n++;
      @(negedge clk);
    end
    #1;
    chk("dto.cycles", n, 16);
    chk("dto.state", bus.state, S_TRAP);
    chk("dto.cause", bus.trap_cause, 3);
    chk("dto.trap", bus.trap, 1);
    @(negedge clk);

    // imem ready exactly at the limit wins
    do_reset();
    drive(1, O_R, 0, 0, 0, 1);
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      bus.imem_ready = (k == 15);
      #1;
      chk($sformatf("ilim%0d.state", k),
          bus.state, S_F);
      @(negedge clk);
    end
    #1;
    chk("ilim.next", bus.state, S_D);
    chk("ilim.cause", bus.trap_cause, 0);
    @(negedge clk);

    // imem timeout
    do_reset();
    drive(1, O_R, 0, 0, 0, 1);
    @(negedge clk);
    n = 0;
    while (bus.state == S_F && n < 40) begin
      n++;
      @(negedge clk);
    end
    #1;
    chk("ito.cycles", n, 16);
    chk("ito.state", bus.state, S_TRAP);
    chk("ito.cause", bus.trap_cause, 2);
    @(negedge clk);

    // BNE is not supported -> illegal
    do_reset();
    drive(1, O_BR, 3'b001, 0, 1, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("bne.state", bus.state, S_TRAP);
    chk("bne.cause", bus.trap_cause, 1);
    chk("bne.cyc", bus.cycle_cnt, pc(2));
    chk("bne.ret", bus.instret_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
